// File: rtl/final_module.sv
// final_module: output stage of the pipelined 8-bit iterative divider.
// Takes the final remainder/quotient magnitudes and operand signs, restores
// two's-complement signs, flags divide-by-zero and overflow, and buffers the
// signed results behind a valid/ready handshake (S1 register + 2-entry FIFO)
// so downstream backpressure can stall the divider without losing results.
module final_module (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] temp_in,
  input  logic [9:0]  item_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        div0,
  output logic        ovf
);

  // Stage register S1 holding one finished division awaiting sign restore
  logic        s1_valid;
  logic [15:0] s1_temp;
  logic [9:0]  s1_item;

  // Two-entry result FIFO, each entry packed as {ovf, div0, remainder, quotient}
  logic [17:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        accept;
  logic        push;
  logic        pop;
  logic [17:0] result;

  logic        q_sign;
  logic        r_sign;
  logic [7:0]  q_mag;
  logic [7:0]  r_mag;
  logic [7:0]  d_mag;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  // S1 may drain whenever the FIFO has room, including room freed by a pop
  // in the same cycle; a full FIFO with a pop keeps count at 2.
  assign push      = s1_valid && ((count != 2'd2) || pop);

  // The out_ready term lets a full pipeline keep streaming at one per cycle.
  assign in_ready  = !s1_valid || (count != 2'd2) || (out_ready && (count != 2'd0));
  assign accept    = in_valid && in_ready;

  assign {ovf, div0, remainder, quotient} = fifo_mem[rd_ptr];

  // Sign restoration, divide-by-zero and overflow handling on the S1 contents
  always_comb begin
    q_mag  = s1_temp[7:0];
    r_mag  = s1_temp[15:8];
    d_mag  = s1_item[9:2];
    q_sign = s1_item[1] ^ s1_item[0];
    r_sign = s1_item[1];
    result = '0;
    if (d_mag == 8'h00) begin
      result = {1'b0, 1'b1, 8'h00, 8'hFF};
    end else begin
      result[7:0]  = q_sign ? (~q_mag + 8'd1) : q_mag;
      result[15:8] = r_sign ? (~r_mag + 8'd1) : r_mag;
      if (!q_sign && (q_mag == 8'h80)) begin
        result[7:0] = 8'h7F;
        result[17]  = 1'b1;
      end
    end
  end

  // Load S1 on an accepted input, free it when its result moves to the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_temp  <= '0;
      s1_item  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_temp  <= temp_in;
      s1_item  <= item_in;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  // FIFO storage, pointers and occupancy; entries are cleared on reset so the
  // outputs read zero until the first result arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= result;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_final_module.sv
// tb_final_module: self-checking bench for the divider output stage.
// Expected results are queued when an input is accepted and compared
// against the buffer head every cycle the output is valid.
module tb_final_module;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] temp_in;
  logic [9:0]  item_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div0;
  logic        ovf;

  typedef struct {
    logic [15:0] temp;
    logic [9:0]  item;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        d0;
    logic        ov;
  } vec_t;

  vec_t        vecs [11];
  logic [17:0] sb [$];
  int          check_count = 0;
  int          pass_count  = 0;
  int          stalls      = 0;
  int          mode        = 0;

  final_module dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .temp_in   (temp_in),
    .item_in   (item_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out_ready pattern: 0 = held low, 1 = held high, 2 = random each cycle
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        1:       out_ready = 1'b1;
        2:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    check_count++;
    $display("[TB] FAIL %s: bound expired, no response", name);
  endtask

  // Signed reference: plain integer division, truncating toward zero
  function automatic logic [17:0] refModel(input int a, input int b);
    int q;
    int r;
    logic v;
    if (b == 0) return {1'b0, 1'b1, 8'h00, 8'hFF};
    q = a / b;
    r = a % b;
    v = 1'b0;
    if (q > 127) begin
      q = 127;
      v = 1'b1;
    end
    return {v, 1'b0, r[7:0], q[7:0]};
  endfunction

  // Build the magnitude/sign words the last iteration stage would deliver
  function automatic void encodeOp(input int a, input int b, output logic [15:0] temp, output logic [9:0] item);
    int am;
    int bm;
    am = (a < 0) ? -a : a;
    bm = (b < 0) ? -b : b;
    if (bm == 0) begin
      temp = 16'($urandom);
    end else begin
      temp[7:0]  = 8'(am / bm);
      temp[15:8] = 8'(am % bm);
    end
    item = {8'(bm), (a < 0), (b < 0)};
  endfunction

  // Offer one input and wait (bounded) for it to be accepted
  task automatic applyStimulus(input logic [15:0] temp, input logic [9:0] item, input logic [17:0] expected);
    int waits;
    bit ok;
    waits    = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    temp_in  = temp;
    item_in  = item;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      waits++;
      if (waits > 1000) break;
    end
    if (ok) begin
      sb.push_back(expected);
      @(posedge clk);
      #1;
    end else begin
      failNow("accept_timeout");
    end
    in_valid = 1'b0;
  endtask

  task automatic applyRandom();
    int a;
    int b;
    logic [15:0] t;
    logic [9:0]  it;
    a = int'($urandom_range(255)) - 128;
    b = int'($urandom_range(255)) - 128;
    if ($urandom_range(15) == 0) b = 0;
    encodeOp(a, b, t, it);
    applyStimulus(t, it, refModel(a, b));
  endtask

  task automatic setMode(input int m);
    mode = m;
    @(posedge clk);
    #3;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while ((sb.size() != 0 || out_valid) && n < 2000);
    if (n >= 2000) failNow("drain_timeout");
  endtask

  // Compare the buffer head with the oldest expected result while it is valid
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        checkOutput("out_data", 32'({ovf, div0, remainder, quotient}), 32'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    vecs[0]  = '{16'h0103, 10'h00A, 8'hFD, 8'hFF, 1'b0, 1'b0};
    vecs[1]  = '{16'h0080, 10'h007, 8'h7F, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{16'h0080, 10'h006, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{16'h1234, 10'h002, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{16'h0103, 10'h008, 8'h03, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{16'h0103, 10'h009, 8'hFD, 8'h01, 1'b0, 1'b0};
    vecs[6]  = '{16'h0103, 10'h00B, 8'h03, 8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{16'h007F, 10'h004, 8'h7F, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 10'h014, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{16'h0001, 10'h203, 8'h01, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{16'h0002, 10'h00E, 8'hFE, 8'h00, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    temp_in  = '0;
    item_in  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_flags", 32'({div0, ovf}), 32'd0);
    @(posedge clk);
    #1;

    // Two-cycle latency on the sign-restore example
    setMode(1);
    applyStimulus(vecs[0].temp, vecs[0].item, {vecs[0].ov, vecs[0].d0, vecs[0].r, vecs[0].q});
    @(negedge clk);
    checkOutput("latency_one_cycle", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_two_cycles", 32'(out_valid), 32'd1);
    waitDrain();

    // Table-driven vectors, back to back
    foreach (vecs[i])
      applyStimulus(vecs[i].temp, vecs[i].item, {vecs[i].ov, vecs[i].d0, vecs[i].r, vecs[i].q});
    waitDrain();

    // Backpressure: exactly three results fit, the fourth waits
    setMode(0);
    begin
      logic [15:0] t4;
      logic [9:0]  i4;
      logic [15:0] t5;
      logic [9:0]  i5;
      applyRandom();
      applyRandom();
      applyRandom();
      encodeOp(-100, 7, t4, i4);
      encodeOp(55, -3, t5, i5);
      in_valid = 1'b1;
      temp_in  = t4;
      item_in  = i4;
      repeat (3) begin
        @(negedge clk);
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      end
      setMode(1);
      applyStimulus(t4, i4, refModel(-100, 7));
      applyStimulus(t5, i5, refModel(55, -3));
    end
    waitDrain();

    // Full-rate streaming: no input stall once out_ready is held high
    stalls = 0;
    repeat (256) applyRandom();
    checkOutput("stream_stalls", 32'(stalls), 32'd0);
    waitDrain();

    // Random backpressure: order and count preserved
    setMode(2);
    repeat (256) applyRandom();
    setMode(1);
    waitDrain();
    checkOutput("random_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with three results buffered
    setMode(0);
    applyRandom();
    applyRandom();
    applyRandom();
    @(negedge clk);
    checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_quotient", 32'(quotient), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    setMode(1);
    applyStimulus(vecs[1].temp, vecs[1].item, {vecs[1].ov, vecs[1].d0, vecs[1].r, vecs[1].q});
    waitDrain();
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/final_module.md
# final_module

Output stage of the pipelined 8-bit iterative divider: the counterpart of the initialisation stage. It receives the final 16-bit working space (remainder/quotient magnitudes) and the 10-bit item word (divisor magnitude and operand signs) from the last iteration stage. It restores two's-complement signs, flags divide-by-zero and overflow, and presents signed results through a valid/ready output with a 2-entry buffer. This lets downstream backpressure stall the divider without losing results.

## Interface
- No parameters; all widths are fixed (8-bit divider).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  temp_in/item_in carry a finished division.
- in_ready  out  1  stage can accept this cycle.
- temp_in  in  16  [15:8] remainder magnitude, [7:0] quotient magnitude (unsigned).
- item_in  in  10  [9:2] divisor magnitude, [1] dividend sign, [0] divisor sign.
- out_valid  out  1  head of output buffer is valid.
- out_ready  in  1  consumer takes head this cycle.
- quotient  out  8  signed quotient, truncated toward zero.
- remainder  out  8  signed remainder; sign follows the dividend.
- div0  out  1  divisor magnitude was zero.
- ovf  out  1  quotient not representable (−128 / −1).

## Operation
- Accept: in_valid && in_ready at a rising edge loads stage register S1 (temp, item, s1_valid=1).
- Compute from S1 (combinational, 18-bit result {ovf, div0, remainder, quotient}):
  - qs = item[1] ^ item[0]; rs = item[1].
  - div0 = (item[9:2] == 0) → quotient 8'hFF, remainder 8'h00, ovf 0.
  - Otherwise quotient = qs ? (~qmag + 1) : qmag; remainder = rs ? (~rmag + 1) : rmag (8-bit wrap; magnitude 8'h80 with sign 1 gives 8'h80 = −128).
  - Overflow: !qs && qmag == 8'h80 → quotient 8'h7F (saturate), ovf 1, remainder as computed.
- S1 drains into a 2-entry FIFO when count<2 or a pop happens in the same cycle; otherwise S1 holds.
- in_ready = !s1_valid || count<2 || (out_ready && count>0). This is a combinational path from out_ready; it is required for full throughput.
- out_valid = count>0; outputs show the FIFO head; pop = out_valid && out_ready.
- Simultaneous push and pop with count==2: legal; count stays 2 and order is preserved.
- Strict FIFO order; no result dropped or duplicated under any out_ready pattern.
- out_ready with out_valid=0: ignored.

## Timing
- Reset (async assert, synchronous-safe deassert): s1_valid=0, count=0, pointers=0, out_valid=0, quotient=0, remainder=0, div0=0, ovf=0, in_ready=1.
- Reset mid-operation: all in-flight results discarded; first post-reset output comes only from new accepts.
- Latency: accept at edge k → out_valid high after edge k+1 (2 cycles), when the buffer is not full.
- Throughput: 1 result/cycle with out_ready held high.
- Capacity: 3 results in flight (S1 + 2 FIFO). With out_ready=0, in_ready falls only when S1 and the FIFO are both full.
- Output data is stable while out_valid && !out_ready.

## Test plan
- Sign restore: temp 16'h0103, item 10'h00A (−7/2) → quotient 8'hFD, remainder 8'hFF, div0 0, ovf 0, out_valid 2 cycles after accept.
- Overflow: temp 16'h0080, item 10'h007 (−128/−1) → quotient 8'h7F, remainder 8'h00, ovf 1; temp 16'h0080, item 10'h006 (−128/1) → quotient 8'h80, ovf 0.
- Divide-by-zero: item 10'h002, any temp → quotient 8'hFF, remainder 8'h00, div0 1.
- Backpressure: out_ready=0, offer 5 back-to-back inputs → exactly 3 accepted, then in_ready=0. Release out_ready → 3 results in order, each held stable while stalled; remaining inputs then accepted.
- Streaming: 256 random operands with out_ready=1 → one result per cycle after a 2-cycle fill, matching a signed reference model. Repeat with random out_ready and check no loss or reorder.
- Reset mid-stream: assert rst_n low with 3 results buffered → out_valid 0 immediately and in_ready 1 after release; no stale results appear.
